// File: rtl/tx_port_pkg.sv
// Shared state type, constants and length helpers for the RIFFA TX port request generator.
package tx_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int C_PCIE_BOUNDARY     = 4096;
  localparam int C_MAX_PAYLOAD_WORDS = 256;

  function automatic logic [31:0] mps_words(input logic [2:0] mps);
    logic [31:0] w;
    if (mps >= 3'd3) w = 32'(C_MAX_PAYLOAD_WORDS);
    else             w = 32'd32 << mps;
    return w;
  endfunction

  // ceil(len / dwords-per-beat); a 256-dword request on a 32-bit path wraps the 8-bit field
  function automatic logic [7:0] beats(input logic [9:0] len, input int width);
    logic [31:0] wpb;
    wpb = 32'(width / 32);
    return 8'(({22'd0, len} + wpb - 32'd1) / wpb);
  endfunction

endpackage

// File: rtl/tx_port_len_calc.sv
// Combinational request sizing: min of element, transaction, max-payload and 4 KB boundary
// lengths, plus the beat count and last flag for that request.
module tx_port_len_calc
  import tx_port_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128
) (
  input  logic [31:0] elem_rem,
  input  logic [31:0] txn_rem,
  input  logic [2:0]  mps,
  input  logic [11:0] addr_lo,
  output logic [9:0]  len,
  output logic [7:0]  beat_cnt,
  output logic        last
);

  logic [31:0] bnd_words;
  logic [31:0] min_data;
  logic [31:0] min_limit;
  logic [31:0] min_all;

  always_comb begin
    bnd_words = (32'(C_PCIE_BOUNDARY) - {20'd0, addr_lo}) >> 2;
    min_data  = (elem_rem < txn_rem) ? elem_rem : txn_rem;
    min_limit = (mps_words(mps) < bnd_words) ? mps_words(mps) : bnd_words;
    min_all   = (min_data < min_limit) ? min_data : min_limit;
    // min_limit never exceeds 256, so the request length always fits 10 bits
    len       = 10'(min_all);
    beat_cnt  = beats(len, C_DATA_WIDTH);
    last      = (min_all == txn_rem);
  end

endmodule

// File: rtl/tx_port_req_gen.sv
// RIFFA TX port request generator: walks SG elements and issues split TX engine write requests.
// Optional SG error abort is compiled in with `define TX_REQ_GEN_ERR_EN.
module tx_port_req_gen
  import tx_port_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  CONFIG_MAX_PAYLOAD_SIZE,
  input  logic        TXN,
  output logic        TXN_ACK,
  input  logic [31:0] TXN_LEN,
  input  logic        SG_ELEM_RDY,
  input  logic        SG_ELEM_EMPTY,
  input  logic [63:0] SG_ELEM_ADDR,
  input  logic [31:0] SG_ELEM_LEN,
  output logic        SG_ELEM_REN,
  input  logic        SG_ERR,
  output logic        SG_RST,
  output logic        TX_REQ,
  input  logic        TX_REQ_ACK,
  output logic [63:0] TX_ADDR,
  output logic [9:0]  TX_LEN,
  output logic        TX_LAST,
  output logic [7:0]  TX_BEATS,
  input  logic        TX_SENT,
  output logic        DONE,
  output logic [31:0] DONE_LEN,
  output logic        DONE_ERR,
  input  logic        DONE_ACK
);

  localparam int C_OUT_WIDTH = $clog2(C_MAX_OUTSTANDING + 1);

  state_t                 state;
  logic [31:0]            txn_rem;
  logic [31:0]            elem_rem;
  logic [31:0]            sent_len;
  logic [63:0]            addr;
  logic                   err_seen;
  logic [C_OUT_WIDTH-1:0] outstanding;
  logic [C_OUT_WIDTH-1:0] outstanding_next;
  logic                   slot_free;
  logic                   req_acc;
  logic                   sent_acc;
  logic                   sg_err_act;
  logic [9:0]             calc_len;
  logic [7:0]             calc_beats;
  logic                   calc_last;

  tx_port_len_calc #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_len_calc (
    .elem_rem (elem_rem),
    .txn_rem  (txn_rem),
    .mps      (CONFIG_MAX_PAYLOAD_SIZE),
    .addr_lo  (addr[11:0]),
    .len      (calc_len),
    .beat_cnt (calc_beats),
    .last     (calc_last)
  );

  assign req_acc  = TX_REQ & TX_REQ_ACK;
  assign sent_acc = TX_SENT & (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    if (req_acc & ~sent_acc)      outstanding_next = outstanding + C_OUT_WIDTH'(1);
    else if (sent_acc & ~req_acc) outstanding_next = outstanding - C_OUT_WIDTH'(1);
  end

  // Decisions use the post-update count so a TX_SENT frees a slot in the very next cycle
  assign slot_free = (outstanding_next < C_OUT_WIDTH'(C_MAX_OUTSTANDING));

`ifdef TX_REQ_GEN_ERR_EN
  assign sg_err_act = SG_ERR & ((state == S_FETCH) | (state == S_CALC) | (state == S_REQ));
`else
  logic sg_err_unused;
  assign sg_err_unused = SG_ERR;
  assign sg_err_act    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      txn_rem     <= '0;
      elem_rem    <= '0;
      sent_len    <= '0;
      addr        <= '0;
      err_seen    <= 1'b0;
      outstanding <= '0;
      TXN_ACK     <= 1'b0;
      SG_ELEM_REN <= 1'b0;
      SG_RST      <= 1'b0;
      TX_REQ      <= 1'b0;
      TX_ADDR     <= '0;
      TX_LEN      <= '0;
      TX_LAST     <= 1'b0;
      TX_BEATS    <= '0;
      DONE        <= 1'b0;
      DONE_LEN    <= '0;
      DONE_ERR    <= 1'b0;
    end else begin
      TXN_ACK     <= 1'b0;
      SG_ELEM_REN <= 1'b0;
      SG_RST      <= 1'b0;
      outstanding <= outstanding_next;

      case (state)
        S_IDLE: begin
          if (TXN) begin
            TXN_ACK  <= 1'b1;
            txn_rem  <= TXN_LEN;
            sent_len <= '0;
            err_seen <= 1'b0;
            state    <= (TXN_LEN == '0) ? S_DRAIN : S_FETCH;
          end
        end

        S_FETCH: begin
          if (SG_ELEM_RDY) begin
            SG_ELEM_REN <= 1'b1;
            addr        <= SG_ELEM_ADDR;
            elem_rem    <= SG_ELEM_LEN;
            // An empty element carries nothing to request; just consume it
            if (SG_ELEM_LEN != '0) state <= S_CALC;
          end else if (SG_ELEM_EMPTY) begin
            state <= S_DRAIN;
          end
        end

        S_CALC: begin
          TX_ADDR  <= addr;
          TX_LEN   <= calc_len;
          TX_BEATS <= calc_beats;
          TX_LAST  <= calc_last;
          TX_REQ   <= slot_free;
          state    <= S_REQ;
        end

        S_REQ: begin
          if (req_acc) begin
            TX_REQ   <= 1'b0;
            addr     <= addr + {52'd0, TX_LEN, 2'b00};
            elem_rem <= elem_rem - {22'd0, TX_LEN};
            txn_rem  <= txn_rem - {22'd0, TX_LEN};
            sent_len <= sent_len + {22'd0, TX_LEN};
            if (txn_rem == {22'd0, TX_LEN})       state <= S_DRAIN;
            else if (elem_rem == {22'd0, TX_LEN}) state <= S_FETCH;
            else                                  state <= S_CALC;
          end else if (!TX_REQ) begin
            TX_REQ <= slot_free;
          end
        end

        S_DRAIN: begin
          if (outstanding_next == '0) begin
            DONE     <= 1'b1;
            DONE_LEN <= sent_len;
            DONE_ERR <= err_seen;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          if (DONE_ACK) begin
            DONE     <= 1'b0;
            DONE_ERR <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Abort overrides the normal next state; a same-cycle ACK above still counts
      if (sg_err_act) begin
        TX_REQ   <= 1'b0;
        SG_RST   <= 1'b1;
        err_seen <= 1'b1;
        state    <= S_DRAIN;
      end
    end
  end

endmodule
